axis_rr_packet_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one AXI-Stream master port among NUM_SRC AXI-Stream sources, such as several instances of the team's burst-generator stream masters. Once a source is granted, it owns the output until its TLAST beat is accepted. The output is fully registered, so TVALID, TDATA and TLAST come straight from flops. Also exposes the current grant and a count of forwarded packets for debug and status registers.

---
 rtl/axis_rr_packet_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_axis_rr_packet_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_packet_arbiter.sv
// Purpose: packet-granular round-robin arbiter muxing NUM_SRC AXI-Stream sources onto one registered master port.
// Latency: request in cycle 0, grant at edge 1, first beat on M_AXIS in cycle 2; one input idle cycle between packets.
// Backpressure: granted source sees TREADY = !M_AXIS_TVALID || M_AXIS_TREADY; all other sources see 0.
//
// Ports:
//   M_AXIS_ACLK / M_AXIS_ARESET        clock (rising edge), asynchronous active-high reset
//   S_AXIS_T{VALID,DATA,LAST,READY}    per-source slave streams; source i data at [i*W +: W]
//   M_AXIS_T{VALID,DATA,STRB,LAST}     registered master stream (TSTRB tied to all ones)
//   M_AXIS_TREADY                      downstream ready
//   grant_idx                          current or most recent granted source
//   grant_active                       high while a packet grant is held
//   pkt_count                          wrapping count of packets whose TLAST beat left on the master side
module axis_rr_packet_arbiter #(
    parameter int NUM_SRC            = 4,
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int PKT_CNT_WIDTH      = 16,
    localparam int IDX_W             = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                                  M_AXIS_ACLK,
    input  logic                                  M_AXIS_ARESET,

    input  logic [NUM_SRC-1:0]                    S_AXIS_TVALID,
    input  logic [NUM_SRC*C_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [NUM_SRC-1:0]                    S_AXIS_TLAST,
    output logic [NUM_SRC-1:0]                    S_AXIS_TREADY,

    output logic                                  M_AXIS_TVALID,
    output logic [C_AXIS_TDATA_WIDTH-1:0]         M_AXIS_TDATA,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]       M_AXIS_TSTRB,
    output logic                                  M_AXIS_TLAST,
    input  logic                                  M_AXIS_TREADY,

    output logic [IDX_W-1:0]                      grant_idx,
    output logic                                  grant_active,
    output logic [PKT_CNT_WIDTH-1:0]              pkt_count
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                          state_q,     state_d;
    logic [IDX_W-1:0]                grant_idx_q, grant_idx_d;
    logic                            m_tvalid_q,  m_tvalid_d;
    logic [C_AXIS_TDATA_WIDTH-1:0]   m_tdata_q,   m_tdata_d;
    logic                            m_tlast_q,   m_tlast_d;
    logic [PKT_CNT_WIDTH-1:0]        pkt_count_q, pkt_count_d;

    // Output register can take a new beat: empty now, or draining this cycle.
    logic                            out_free;
    logic                            out_accept;
    logic                            in_accept;

    logic                            sel_tvalid;
    logic                            sel_tlast;
    logic [C_AXIS_TDATA_WIDTH-1:0]   sel_tdata;

    logic                            arb_found;
    logic [IDX_W-1:0]                arb_idx;

    logic [NUM_SRC-1:0]              s_tready;

    assign out_free   = !m_tvalid_q || M_AXIS_TREADY;
    assign out_accept = m_tvalid_q && M_AXIS_TREADY;

    // Granted-source mux. grant_idx_q only ever holds a legal source index.
    always_comb begin
        sel_tvalid = 1'b0;
        sel_tlast  = 1'b0;
        sel_tdata  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_idx_q == IDX_W'(i)) begin
                sel_tvalid = S_AXIS_TVALID[i];
                sel_tlast  = S_AXIS_TLAST[i];
                sel_tdata  = S_AXIS_TDATA[i*C_AXIS_TDATA_WIDTH +: C_AXIS_TDATA_WIDTH];
            end
        end
    end

    // Round-robin search: first valid source scanning cyclically from the
    // one after the most recent grant. The inner constant loop turns the
    // rotated candidate into a per-source compare, so no index wider than
    // the vector is ever used to select a bit.
    always_comb begin
        int cand;
        cand      = 0;
        arb_found = 1'b0;
        arb_idx   = grant_idx_q;
        for (int off = 1; off <= NUM_SRC; off++) begin
            cand = int'(grant_idx_q) + off;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!arb_found && (cand == i) && S_AXIS_TVALID[i]) begin
                    arb_found = 1'b1;
                    arb_idx   = IDX_W'(i);
                end
            end
        end
    end

    // Only the granted source is offered ready, and only while in SEND.
    always_comb begin
        s_tready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if ((state_q == ST_SEND) && (grant_idx_q == IDX_W'(i))) begin
                s_tready[i] = out_free;
            end
        end
    end

    assign in_accept = (state_q == ST_SEND) && sel_tvalid && out_free;

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        m_tvalid_d  = m_tvalid_q;
        m_tdata_d   = m_tdata_q;
        m_tlast_d   = m_tlast_q;
        pkt_count_d = pkt_count_q;

        case (state_q)
            ST_IDLE: begin
                // May run while the previous packet's last beat still sits
                // in the output register; that beat drains independently.
                if (arb_found) begin
                    grant_idx_d = arb_idx;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                // A stalled granted source keeps the grant; no re-arbitration
                // until its TLAST beat has been taken.
                if (in_accept && sel_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Load wins over drain so a simultaneous load+drain streams back-to-back.
        if (in_accept) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = sel_tdata;
            m_tlast_d  = sel_tlast;
        end else if (out_accept) begin
            m_tvalid_d = 1'b0;
        end

        if (out_accept && m_tlast_q) begin
            pkt_count_d = pkt_count_q + PKT_CNT_WIDTH'(1);
        end
    end

    // Reset points grant_idx at the last source so source 0 wins first.
    always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
        if (M_AXIS_ARESET) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= IDX_W'(NUM_SRC - 1);
            m_tvalid_q  <= 1'b0;
            m_tdata_q   <= '0;
            m_tlast_q   <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tdata_q   <= m_tdata_d;
            m_tlast_q   <= m_tlast_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign S_AXIS_TREADY = s_tready;
    assign M_AXIS_TVALID = m_tvalid_q;
    assign M_AXIS_TDATA  = m_tdata_q;
    assign M_AXIS_TLAST  = m_tlast_q;
    assign M_AXIS_TSTRB  = '1;
    assign grant_idx     = grant_idx_q;
    assign grant_active  = (state_q == ST_SEND);
    assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Purpose: randomized scoreboard bench for axis_rr_packet_arbiter.
// Latency: expected packet order comes from a queue-level round-robin model over pending packets.
// Backpressure: random or directed M_AXIS_TREADY stalls; granted sources may pause mid-packet.
module tb_axis_rr_packet_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NS-1:0]   s_tvalid;
    logic [NS*DW-1:0] s_tdata;
    logic [NS-1:0]   s_tlast;
    logic [NS-1:0]   s_tready;
    logic            m_tvalid;
    logic [DW-1:0]   m_tdata;
    logic [DW/8-1:0] m_tstrb;
    logic            m_tlast;
    logic            m_tready;
    logic [IW-1:0]   grant_idx;
    logic            grant_active;
    logic [CW-1:0]   pkt_count;

    always #5 clk = ~clk;

    axis_rr_packet_arbiter #(
        .NUM_SRC            (NS),
        .C_AXIS_TDATA_WIDTH (DW),
        .PKT_CNT_WIDTH      (CW)
    ) dut (
        .M_AXIS_ACLK   (clk),
        .M_AXIS_ARESET (rst),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TLAST  (s_tlast),
        .S_AXIS_TREADY (s_tready),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TSTRB  (m_tstrb),
        .M_AXIS_TLAST  (m_tlast),
        .M_AXIS_TREADY (m_tready),
        .grant_idx     (grant_idx),
        .grant_active  (grant_active),
        .pkt_count     (pkt_count)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t sq     [NS][$];   // beats each source still has to send
    int    mdl_id [NS][$];   // model: pending packet ids per source
    int    mdl_len[NS][$];   // model: pending packet lengths per source
    beat_t exp_q  [$];       // scoreboard: expected master-side beats in order

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int ptr   = NS - 1;      // model: most recent grant
    int total = 0;           // model: packets forwarded since reset
    int pkt_id = 0;

    int bidx[NS];
    int drop_left[NS];
    int dir_drop_src = -1;
    int stall_at = -1;
    int rdy_low_left = 0;
    bit strict = 1'b0;
    bit rdy_rand = 1'b0;
    bit drop_rand = 1'b0;

    int m_beats = 0;
    int first_mv_cyc = -1;
    int phase_start_cyc = 0;
    bit have_prev = 1'b0;
    int last_cyc = 0;
    bit last_last = 1'b0;
    bit have_m = 1'b0;
    int last_m_cyc = 0;
    bit last_m_last = 1'b1;
    bit prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic prev_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int s, input int id, input int b);
        logic [DW-1:0] d;
        d = {s[7:0], id[7:0], b[15:0]};
        return d;
    endfunction

    task automatic add_pkt(input int s, input int len);
        beat_t x;
        for (int b = 0; b < len; b++) begin
            x.data = mk_data(s, pkt_id, b);
            x.last = (b == len - 1);
            sq[s].push_back(x);
        end
        mdl_id[s].push_back(pkt_id);
        mdl_len[s].push_back(len);
        pkt_id++;
    endtask

    // Reference: each packet goes to the first source with pending packets
    // after the previous winner, cyclically; packets are never interleaved.
    task automatic model_order();
        bit any;
        int s, id, len;
        beat_t x;
        for (int k = 0; k < 10000; k++) begin
            any = 1'b0;
            s = 0;
            for (int off = 1; off <= NS && !any; off++) begin
                s = (ptr + off) % NS;
                if (mdl_id[s].size() != 0) any = 1'b1;
            end
            if (!any) break;
            id  = mdl_id[s].pop_front();
            len = mdl_len[s].pop_front();
            for (int b = 0; b < len; b++) begin
                x.data = mk_data(s, id, b);
                x.last = (b == len - 1);
                exp_q.push_back(x);
            end
            ptr = s;
            total++;
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NS; i++) begin
            if (drop_left[i] != 0) begin
                drop_left[i]--;
            end else if (bidx[i] == 2 && i == dir_drop_src) begin
                drop_left[i] = 3;
                dir_drop_src = -1;
            end else if (bidx[i] != 0 && drop_rand && $urandom_range(0, 5) == 0) begin
                drop_left[i] = $urandom_range(1, 3);
            end
            if (sq[i].size() != 0 && drop_left[i] == 0) begin
                s_tvalid[i] = 1'b1;
                s_tdata[i*DW +: DW] = sq[i][0].data;
                s_tlast[i] = sq[i][0].last;
            end else begin
                s_tvalid[i] = 1'b0;
                s_tdata[i*DW +: DW] = $urandom;
                s_tlast[i] = 1'($urandom_range(0, 1));
            end
        end
        if (stall_at >= 0 && m_beats >= stall_at) begin
            rdy_low_left = 5;
            stall_at = -1;
        end
        if (rdy_low_left > 0) begin
            m_tready = 1'b0;
            rdy_low_left--;
        end else begin
            m_tready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    endtask

    task automatic step();
        beat_t b;
        @(negedge clk);
        if (!rst) begin
            for (int i = 0; i < NS; i++) begin
                if (s_tvalid[i] && s_tready[i]) begin
                    b = sq[i].pop_front();
                    chk("s_hs_grant_idx", grant_idx, i);
                    chk("s_hs_grant_active", grant_active, 1);
                    if (strict && have_prev) chk("s_hs_gap", cyc - last_cyc, last_last ? 2 : 1);
                    have_prev = 1'b1;
                    last_cyc  = cyc;
                    last_last = b.last;
                    bidx[i]   = b.last ? 0 : bidx[i] + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic flush();
        for (int i = 0; i < NS; i++) begin
            sq[i].delete();
            mdl_id[i].delete();
            mdl_len[i].delete();
            bidx[i] = 0;
            drop_left[i] = 0;
        end
        exp_q.delete();
        ptr = NS - 1;
        total = 0;
        s_tvalid = '0;
        rdy_low_left = 0;
        stall_at = -1;
        dir_drop_src = -1;
    endtask

    // Called just after a rising edge: reset lands mid-cycle.
    task automatic apply_reset(input string name);
        #1 rst = 1'b1;
        #1;
        chk({name, "_m_tvalid"}, m_tvalid, 0);
        chk({name, "_m_tdata"}, m_tdata, 0);
        chk({name, "_m_tlast"}, m_tlast, 0);
        chk({name, "_s_tready"}, s_tready, 0);
        chk({name, "_grant_active"}, grant_active, 0);
        chk({name, "_pkt_count"}, pkt_count, 0);
        chk({name, "_grant_idx"}, grant_idx, NS - 1);
        flush();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive_inputs();
    endtask

    task automatic run_phase(input string name);
        int  n;
        bit  busy;
        n = 0;
        model_order();
        have_prev = 1'b0;
        have_m    = 1'b0;
        m_beats   = 0;
        step();
        phase_start_cyc = cyc;
        busy = 1'b1;
        while (busy && n < 3000) begin
            step();
            n++;
            busy = (exp_q.size() != 0);
            for (int i = 0; i < NS; i++) if (sq[i].size() != 0) busy = 1'b1;
        end
        if (busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: %0d beats still expected after %0d cycles, required 0", name, exp_q.size(), n);
            flush();
        end
        repeat (3) step();
        chk({name, "_pkt_count"}, pkt_count, total % (1 << CW));
    endtask

    // Monitor: compares every master-side handshake against the scoreboard
    // and checks hold stability and ready gating every cycle.
    initial begin : monitor
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
                have_m = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk("m_hold_valid", m_tvalid, 1);
                    chk("m_hold_data", m_tdata, prev_data);
                    chk("m_hold_last", m_tlast, prev_last);
                end
                chk("m_tstrb", m_tstrb, {(DW/8){1'b1}});
                if (!grant_active) chk("idle_s_tready", s_tready, 0);
                else chk("nongrant_s_tready", s_tready & ~(NS'(1) << grant_idx), 0);
                if (m_tvalid && !m_tready) chk("stall_s_tready", s_tready, 0);
                if (m_tvalid && first_mv_cyc < 0) first_mv_cyc = cyc;
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL m_unexpected_beat: got data 0x%0h, required no beat", m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("m_data", m_tdata, e.data);
                        chk("m_last", m_tlast, e.last);
                    end
                    if (strict && have_m && !last_m_last) chk("m_beat_gap", cyc - last_m_cyc, 1);
                    have_m = 1'b1;
                    last_m_cyc = cyc;
                    last_m_last = m_tlast;
                    m_beats++;
                end
                prev_hold = m_tvalid && !m_tready;
                prev_data = m_tdata;
                prev_last = m_tlast;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "global timeout");
    end

    initial begin : stimulus
        int n;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        for (int i = 0; i < NS; i++) begin
            bidx[i] = 0;
            drop_left[i] = 0;
        end

        apply_reset("reset");

        // Single 8-beat packet from source 0, full throughput.
        strict = 1'b1;
        first_mv_cyc = -1;
        add_pkt(0, 8);
        run_phase("A");
        chk("A_latency", first_mv_cyc - phase_start_cyc, 2);
        chk("A_grant_idx", grant_idx, 0);

        // All sources busy with 2-beat packets: strict rotation and bubbles.
        @(posedge clk);
        apply_reset("B_reset");
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < NS; s++) add_pkt(s, 2);
        run_phase("B");
        chk("B_grant_idx", grant_idx, NS - 1);
        strict = 1'b0;

        // Downstream stall of 5 cycles mid-packet.
        add_pkt(1, 6);
        stall_at = 2;
        run_phase("C");

        // Granted source 2 pauses 3 cycles mid-packet while source 1 waits.
        dir_drop_src = 2;
        add_pkt(1, 3);
        add_pkt(2, 5);
        run_phase("D");
        chk("D_grant_idx", grant_idx, 1);

        // Sources 1 and 3 only; counter wraps past its maximum here.
        rdy_rand = 1'b1;
        for (int r = 0; r < 3; r++) begin
            add_pkt(1, 2);
            add_pkt(3, 2);
        end
        run_phase("E");

        // Random mixes, including single-beat packets and source pauses.
        drop_rand = 1'b1;
        for (int r = 0; r < 5; r++) begin
            for (int s = 0; s < NS; s++) begin
                n = $urandom_range(0, 3);
                for (int k = 0; k < n; k++) add_pkt(s, $urandom_range(1, 5));
            end
            run_phase("F");
        end

        // Asynchronous reset mid-packet, then fresh arbitration from source 0.
        rdy_rand = 1'b0;
        drop_rand = 1'b0;
        for (int s = 0; s < NS; s++) add_pkt(s, 6);
        model_order();
        repeat (5) step();
        chk("G_pre_reset_m_tvalid", m_tvalid, 1);
        chk("G_pre_reset_grant_active", grant_active, 1);
        apply_reset("G_reset");
        for (int s = NS - 1; s >= 0; s--) add_pkt(s, 1);
        run_phase("G");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
